// File: rtl/mem_miss_ctrl.sv
// mem_miss_ctrl: shares one line-wide memory port among NCH cache miss channels.
// A round-robin arbiter grants one channel at a time. A dirty victim is written back
// first (WB), then the missing line is read (FILL), then a one-cycle done pulse
// returns the line to the owner (DONE). All outputs are registered.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   req[NCH]           per-channel miss request (level, held until done)
//   miss_addr          per-channel miss address, channel k at [k*ADDR_W +: ADDR_W]
//   wb_en[NCH]         per-channel dirty-victim flag, sampled at grant
//   wb_addr, wb_data   per-channel victim address / line
//   done[NCH]          one-hot fill-complete pulse
//   fill_data          fill line, valid while done is high, held otherwise
//   busy               high whenever a transaction is in progress
//   mem_addr, mem_re, mem_we, mem_wdata, mem_rdata, mem_rdy   unified memory port
module mem_miss_ctrl #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 16,
    parameter int LINE_W = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*ADDR_W-1:0]  miss_addr,
    input  logic [NCH-1:0]         wb_en,
    input  logic [NCH*ADDR_W-1:0]  wb_addr,
    input  logic [NCH*LINE_W-1:0]  wb_data,
    output logic [NCH-1:0]         done,
    output logic [LINE_W-1:0]      fill_data,
    output logic                   busy,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [LINE_W-1:0]      mem_wdata,
    input  logic [LINE_W-1:0]      mem_rdata,
    input  logic                   mem_rdy
);

    localparam int OFF = $clog2(LINE_W / 16);
    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
    // Clears the word-offset bits so every access is line aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF;

    typedef enum logic [1:0] {
        StIdle,
        StWb,
        StFill,
        StDone
    } state_e;

    state_e            state_q;
    logic [PW-1:0]     owner_q;
    logic [PW-1:0]     ptr_q;
    logic [ADDR_W-1:0] miss_q;

    logic              gnt_any;
    logic [PW-1:0]     gnt_idx;
    logic [PW-1:0]     ptr_next;
    logic [ADDR_W-1:0] sel_miss;
    logic [ADDR_W-1:0] sel_wb_addr;
    logic [LINE_W-1:0] sel_wb_data;

    // Round-robin search: first requesting channel at or after the pointer, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!gnt_any && req[(int'(ptr_q) + i) % NCH]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'((int'(ptr_q) + i) % NCH);
            end
        end
    end

    always_comb begin
        ptr_next    = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
        sel_miss    = miss_addr[int'(gnt_idx) * ADDR_W +: ADDR_W];
        sel_wb_addr = wb_addr[int'(gnt_idx) * ADDR_W +: ADDR_W];
        sel_wb_data = wb_data[int'(gnt_idx) * LINE_W +: LINE_W];
    end

    // Single FSM; every output is a register updated alongside the state.
    // mem_addr / mem_wdata double as the latched victim address / line during WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= '0;
            ptr_q     <= '0;
            miss_q    <= '0;
            busy      <= 1'b0;
            done      <= '0;
            fill_data <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_any) begin
                        owner_q <= gnt_idx;
                        ptr_q   <= ptr_next;
                        miss_q  <= sel_miss & ALIGN_MASK;
                        busy    <= 1'b1;
                        if (wb_en[gnt_idx]) begin
                            state_q   <= StWb;
                            mem_we    <= 1'b1;
                            mem_addr  <= sel_wb_addr & ALIGN_MASK;
                            mem_wdata <= sel_wb_data;
                        end else begin
                            state_q  <= StFill;
                            mem_re   <= 1'b1;
                            mem_addr <= sel_miss & ALIGN_MASK;
                        end
                    end
                end
                StWb: begin
                    if (mem_rdy) begin
                        state_q  <= StFill;
                        mem_we   <= 1'b0;
                        mem_re   <= 1'b1;
                        mem_addr <= miss_q;
                    end
                end
                StFill: begin
                    if (mem_rdy) begin
                        state_q        <= StDone;
                        mem_re         <= 1'b0;
                        fill_data      <= mem_rdata;
                        done[owner_q]  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= '0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
